// File: rtl/fibonacci_pkg.sv
// rtl/fibonacci_pkg.sv - shared types and widths for the Fibonacci generator/checker pair
//
// Purpose: state encoding for the checker FSM, term and counter widths, and a
// saturating increment used by the checker's statistics counters.
// Ports: none (package).

package fibonacci_pkg;

  localparam int FIB_W   = 8;
  localparam int CNT_W   = 16;
  localparam int PHASE_W = 20;

  typedef enum logic [1:0] {
    HUNT0 = 2'd0,
    HUNT1 = 2'd1,
    TRACK = 2'd2
  } fib_state_e;

  // Counters stick at all-ones rather than wrapping back to zero.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/fibonacci_checker_if.sv
// rtl/fibonacci_checker_if.sv - term stream and status bundle between generator side and checker
//
// Purpose: groups the observed term stream and the checker's status outputs.
// Signals:
//   in          term stream from the generator (held DECIMATION clocks per term)
//   locked      checker is tracking the sequence
//   error       one-clock pulse per mismatched term while locked
//   expected    term the checker currently expects
//   term_count  matched terms since reset (saturating)
//   err_count   mismatched terms since reset (saturating)
// Modports: master = stream source / status observer, slave = checker.

interface fibonacci_checker_if;
  import fibonacci_pkg::*;

  logic [FIB_W-1:0] in;
  logic             locked;
  logic             error;
  logic [FIB_W-1:0] expected;
  logic [CNT_W-1:0] term_count;
  logic [CNT_W-1:0] err_count;

  modport master (
    output in,
    input  locked, error, expected, term_count, err_count
  );

  modport slave (
    input  in,
    output locked, error, expected, term_count, err_count
  );

endinterface

// File: rtl/fib_phase_counter.sv
// rtl/fib_phase_counter.sv - modulo-DECIMATION term phase counter with check/advance strobes
//
// Purpose: tracks the position inside the current term while the checker is
// locked. Loading restarts the count at zero on the clock that lock is taken.
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   load       synchronous restart of the phase at zero (priority over en)
//   en         count enable
//   check_stb  high while phase sits at the mid-term check point
//   adv_stb    high while phase sits at the last clock of the term

module fib_phase_counter
  import fibonacci_pkg::*;
#(
  parameter logic [PHASE_W-1:0] DECIMATION = 20'd20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic check_stb,
  output logic adv_stb
);

  localparam logic [PHASE_W-1:0] LAST  = DECIMATION - 20'd1;
  localparam logic [PHASE_W-1:0] CHECK = DECIMATION >> 1;

  logic [PHASE_W-1:0] phase;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= '0;
    end else if (load) begin
      phase <= '0;
    end else if (en) begin
      phase <= (phase == LAST) ? '0 : phase + 20'd1;
    end
  end

  // Checking mid-term keeps the sample away from term edges, absorbing
  // alignment slip of up to half a term in either direction.
  assign check_stb = en && (phase == CHECK);
  assign adv_stb   = en && (phase == LAST);

endmodule

// File: rtl/fibonacci_checker.sv
// rtl/fibonacci_checker.sv - receive-side lock and compare monitor for the Fibonacci term stream
//
// Purpose: hunts for a 0 term followed by a 1 term, then tracks the stream,
// comparing each term mid-way against an internally generated mod-256
// Fibonacci value, and drops lock after LOCK_LOSS consecutive misses.
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous active-low reset
//   fib    slave side of fibonacci_checker_if (in -> checker, status <- checker)

module fibonacci_checker
  import fibonacci_pkg::*;
#(
  parameter logic [PHASE_W-1:0] DECIMATION = 20'd20,
  parameter int                 LOCK_LOSS  = 3
) (
  input  logic                clk,
  input  logic                reset,
  fibonacci_checker_if.slave  fib
);

  localparam logic [3:0] LOCK_LOSS_C = 4'(LOCK_LOSS);

  fib_state_e       state_q, state_d;
  logic             locked_q;
  logic [FIB_W-1:0] in_q;
  logic [FIB_W-1:0] a_q, b_q;
  logic [3:0]       miss_q;
  logic             error_q;
  logic [CNT_W-1:0] term_cnt_q, err_cnt_q;

  logic check_stb, adv_stb;
  logic lock_entry, lock_lost, tracking;

  // Single input register; every decision below looks only at in_q.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) in_q <= '0;
    else        in_q <= fib.in;
  end

  // FSM: state register (locked is registered alongside it).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= HUNT0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      locked_q <= (state_d == TRACK);
    end
  end

  // FSM: next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      HUNT0: if (in_q == 8'd0) state_d = HUNT1;
      HUNT1: begin
        if (in_q == 8'd1)      state_d = TRACK;
        else if (in_q != 8'd0) state_d = HUNT0;
      end
      TRACK: if (miss_q >= LOCK_LOSS_C) state_d = HUNT0;
      default: state_d = HUNT0;
    endcase
  end

  // FSM: output decode driving the datapath.
  always_comb begin
    lock_entry = 1'b0;
    lock_lost  = 1'b0;
    tracking   = 1'b0;
    case (state_q)
      HUNT1: lock_entry = (in_q == 8'd1);
      TRACK: begin
        lock_lost = (miss_q >= LOCK_LOSS_C);
        tracking  = !lock_lost;
      end
      default: ;
    endcase
  end

  fib_phase_counter #(
    .DECIMATION(DECIMATION)
  ) u_phase (
    .clk       (clk),
    .rst_n     (reset),
    .load      (lock_entry),
    .en        (state_q == TRACK),
    .check_stb (check_stb),
    .adv_stb   (adv_stb)
  );

  // Expected-term registers, miss counter and statistics. Lock loss wins
  // over an advance landing on the same clock.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q        <= '0;
      b_q        <= '0;
      miss_q     <= '0;
      error_q    <= 1'b0;
      term_cnt_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      error_q <= 1'b0;
      if (lock_entry) begin
        a_q    <= 8'd0;
        b_q    <= 8'd1;
        miss_q <= '0;
      end else if (lock_lost) begin
        a_q    <= '0;
        b_q    <= '0;
        miss_q <= '0;
      end else if (tracking) begin
        if (check_stb) begin
          if (in_q == b_q) begin
            term_cnt_q <= sat_inc(term_cnt_q);
            miss_q     <= '0;
          end else begin
            error_q   <= 1'b1;
            err_cnt_q <= sat_inc(err_cnt_q);
            miss_q    <= miss_q + 4'd1;
          end
        end
        if (adv_stb) begin
          a_q <= b_q;
          b_q <= a_q + b_q;  // carry dropped: sequence wraps mod 256
        end
      end
    end
  end

  assign fib.locked     = locked_q;
  assign fib.error      = error_q;
  assign fib.expected   = b_q;
  assign fib.term_count = term_cnt_q;
  assign fib.err_count  = err_cnt_q;

endmodule

// File: tb/tb_fibonacci_checker.sv
// tb/tb_fibonacci_checker.sv - directed table-driven bench for fibonacci_checker

module tb_fibonacci_checker;

  typedef struct {
    logic [7:0] term;
    int         dur;
    logic       locked;
    int         tc;
    int         ec;
    logic [7:0] exp;
    int         errs;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  fibonacci_checker_if fib_bus ();

  fibonacci_checker #(
    .DECIMATION(20'd20),
    .LOCK_LOSS (3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .fib   (fib_bus)
  );

  int checks = 0;
  int passed = 0;
  int err_pulses = 0;
  logic       trace_en = 1'b0;
  logic [1:0] trace_last = 2'd0;
  logic [1:0] trace_q[$];

  vec_t       tbl[$];
  logic [7:0] fib_seq[16];
  logic [1:0] exp_trace[4];

  always @(negedge clk) begin
    if (fib_bus.error) err_pulses <= err_pulses + 1;
    if (trace_en && (2'(dut.state_q) != trace_last)) trace_q.push_back(2'(dut.state_q));
    trace_last <= 2'(dut.state_q);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: actual %0d required %0d", name, act, exp);
    else passed++;
  endtask

  task automatic add(input logic [7:0] term, input int dur, input logic locked,
                     input int tc, input int ec, input logic [7:0] exp, input int errs);
    vec_t v;
    v.term = term; v.dur = dur; v.locked = locked;
    v.tc = tc; v.ec = ec; v.exp = exp; v.errs = errs;
    tbl.push_back(v);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".locked"},     32'(fib_bus.locked),     0);
    chk({tag, ".error"},      32'(fib_bus.error),      0);
    chk({tag, ".expected"},   32'(fib_bus.expected),   0);
    chk({tag, ".term_count"}, 32'(fib_bus.term_count), 0);
    chk({tag, ".err_count"},  32'(fib_bus.err_count),  0);
  endtask

  // Reset with in = 0, then release and wait 2 clocks before the stream starts.
  task automatic do_reset(input string tag);
    fib_bus.in = 8'd0;
    reset = 1'b0;
    tick(); tick();
    check_zero({tag, ".rst"});
    reset = 1'b1;
    tick(); tick();
  endtask

  // Build the clean 0,1,1,2..98 table; corrupt_idx replaces that term with 9;
  // slip stretches the first 1 term by 5 clocks so later terms lag by 5.
  task automatic build_stream(input int corrupt_idx, input bit slip);
    int tc, ec, errs, dur;
    logic [7:0] t, e;
    tbl.delete();
    tc = 0; ec = 0;
    for (int i = 0; i < 16; i++) begin
      t = fib_seq[i];
      errs = 0;
      if (i == corrupt_idx) begin
        t = 8'd9; ec++; errs = 1;
      end else if (i > 0) begin
        tc++;
      end
      dur = (slip && i == 1) ? 25 : 20;
      e = fib_seq[i];
      // With lag, the next advance has already happened when a term ends.
      if (slip && i >= 1) e = (i == 15) ? 8'd219 : fib_seq[i+1];
      add(t, dur, (i > 0), tc, ec, e, errs);
    end
  endtask

  task automatic run_table(input string tag);
    int base;
    for (int i = 0; i < tbl.size(); i++) begin
      base = err_pulses;
      fib_bus.in = tbl[i].term;
      repeat (tbl[i].dur) tick();
      chk($sformatf("%s[%0d].locked", tag, i),   32'(fib_bus.locked),     32'(tbl[i].locked));
      chk($sformatf("%s[%0d].tc", tag, i),       32'(fib_bus.term_count), tbl[i].tc);
      chk($sformatf("%s[%0d].ec", tag, i),       32'(fib_bus.err_count),  tbl[i].ec);
      chk($sformatf("%s[%0d].expected", tag, i), 32'(fib_bus.expected),   32'(tbl[i].exp));
      chk($sformatf("%s[%0d].errs", tag, i),     err_pulses - base,       tbl[i].errs);
    end
  endtask

  initial begin
    int base;
    fib_bus.in = 8'd0;
    fib_seq = '{8'd0, 8'd1, 8'd1, 8'd2, 8'd3, 8'd5, 8'd8, 8'd13,
                8'd21, 8'd34, 8'd55, 8'd89, 8'd144, 8'd233, 8'd121, 8'd98};
    exp_trace = '{2'd1, 2'd0, 2'd1, 2'd2};

    // Clean stream
    do_reset("clean");
    build_stream(-1, 1'b0);
    run_table("clean");

    // Single corruption: term 8 sent as 9
    do_reset("corrupt");
    build_stream(6, 1'b0);
    run_table("corrupt");

    // Lock loss on a stuck 200, then relock
    do_reset("loss");
    tbl.delete();
    add(8'd0,   20, 1'b0, 0, 0, 8'd0, 0);
    add(8'd1,   20, 1'b1, 1, 0, 8'd1, 0);
    add(8'd1,   20, 1'b1, 2, 0, 8'd1, 0);
    add(8'd2,   20, 1'b1, 3, 0, 8'd2, 0);
    add(8'd200, 20, 1'b1, 3, 1, 8'd3, 1);
    add(8'd200, 20, 1'b1, 3, 2, 8'd5, 1);
    add(8'd200, 20, 1'b0, 3, 3, 8'd0, 1);
    add(8'd200, 20, 1'b0, 3, 3, 8'd0, 0);
    add(8'd0,   20, 1'b0, 3, 3, 8'd0, 0);
    add(8'd1,   20, 1'b1, 4, 3, 8'd1, 0);
    add(8'd1,   20, 1'b1, 5, 3, 8'd1, 0);
    add(8'd2,   20, 1'b1, 6, 3, 8'd2, 0);
    run_table("loss");

    // False start: 0, 7, 0, 1 with lock latency
    fib_bus.in = 8'd0;
    reset = 1'b0;
    tick(); tick();
    chk("false.rst_state", 32'(dut.state_q), 0);
    base = trace_q.size();
    trace_en = 1'b1;
    reset = 1'b1;
    tick(); tick();
    repeat (20) tick();
    fib_bus.in = 8'd7;
    repeat (20) tick();
    fib_bus.in = 8'd0;
    repeat (20) tick();
    fib_bus.in = 8'd1;
    tick();
    chk("false.locked_1clk", 32'(fib_bus.locked), 0);
    tick();
    chk("false.locked_2clk", 32'(fib_bus.locked), 1);
    repeat (18) tick();
    trace_en = 1'b0;
    chk("false.err_count", 32'(fib_bus.err_count), 0);
    chk("false.term_count", 32'(fib_bus.term_count), 1);
    chk("false.trace_len", trace_q.size() - base, 4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("false.trace[%0d]", i), 32'(trace_q[base + i]), 32'(exp_trace[i]));

    // Phase slip of +5 clocks, then asynchronous reset while tracking
    do_reset("slip");
    build_stream(-1, 1'b1);
    run_table("slip");
    #3 reset = 1'b0;
    #1 check_zero("midrst");
    tick();
    reset = 1'b1;
    repeat (5) tick();
    chk("midrst.rehunt_locked", 32'(fib_bus.locked), 0);
    chk("midrst.rehunt_tc", 32'(fib_bus.term_count), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
